// File: rtl/ctrl_alu_dm_core.sv
// Execution-side core: instruction decode with hazard timing, 32-bit ALU, data memory.
// Define ALU_SLT_EN to add slt decode and the signed-compare ALU operation.
module ctrl_alu_dm_core #(
    parameter int STAGE    = 0,
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        ext,
    output logic [2:0]  npc_op,
    output logic [3:0]  alu_op_o,
    output logic        alu_src,
    output logic        reg_write,
    output logic        mem_write,
    output logic [1:0]  reg_from,
    output logic [1:0]  reg_dst,
    output logic        t_use_rs,
    output logic [1:0]  t_use_rt,
    output logic [1:0]  t_new,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  shamt,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] alu_res,
    output logic        zero,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_LUI = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    // Stages past E have already consumed this many cycles of the E-stage latency.
    localparam int TNEW_SUB = (STAGE > 1) ? (STAGE - 1) : 0;

    logic [5:0] op;
    logic [5:0] funct;
    logic       r_type;
    logic       is_add;
    logic       is_sub;
    logic       is_sll;
    logic       is_jr;
    logic       is_ori;
    logic       is_lui;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_jal;
    logic       is_j;
    logic       is_slt;
    logic [1:0] t_new_e;

    assign op     = instr[31:26];
    assign funct  = instr[5:0];
    assign r_type = (op == 6'h00);
    assign is_add = r_type && (funct == 6'h20);
    assign is_sub = r_type && (funct == 6'h22);
    assign is_sll = r_type && (funct == 6'h00);
    assign is_jr  = r_type && (funct == 6'h08);
    assign is_ori = (op == 6'h0d);
    assign is_lui = (op == 6'h0f);
    assign is_lw  = (op == 6'h23);
    assign is_sw  = (op == 6'h2b);
    assign is_beq = (op == 6'h04);
    assign is_jal = (op == 6'h03);
    assign is_j   = (op == 6'h02);

`ifdef ALU_SLT_EN
    assign is_slt = r_type && (funct == 6'h2a);
`else
    assign is_slt = 1'b0;
`endif

    always_comb begin
        ext       = 1'b0;
        npc_op    = NPC_SEQ;
        alu_op_o  = ALU_ADD;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        reg_from  = 2'd0;
        reg_dst   = 2'd0;
        t_use_rs  = 1'b1;
        t_use_rt  = 2'd3;
        t_new_e   = 2'd0;
        unique case (1'b1)
            is_add, is_sub, is_sll, is_slt: begin
                alu_op_o  = is_add ? ALU_ADD :
                            is_sub ? ALU_SUB :
                            is_sll ? ALU_SLL : ALU_SLT;
                reg_dst   = 2'd1;
                reg_write = 1'b1;
                t_use_rt  = 2'd1;
                t_new_e   = 2'd1;
            end
            is_jr: begin
                npc_op   = NPC_JR;
                t_use_rs = 1'b0;
            end
            is_ori: begin
                alu_op_o  = ALU_OR;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                t_new_e   = 2'd1;
            end
            is_lui: begin
                alu_op_o  = ALU_LUI;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                t_new_e   = 2'd1;
            end
            is_lw: begin
                alu_src   = 1'b1;
                ext       = 1'b1;
                reg_from  = 2'd1;
                reg_write = 1'b1;
                t_new_e   = 2'd2;
            end
            is_sw: begin
                alu_src   = 1'b1;
                ext       = 1'b1;
                mem_write = 1'b1;
                t_use_rt  = 2'd2;
            end
            is_beq: begin
                npc_op   = NPC_BEQ;
                ext      = 1'b1;
                t_use_rs = 1'b0;
                t_use_rt = 2'd0;
            end
            is_jal: begin
                npc_op    = NPC_J;
                reg_from  = 2'd2;
                reg_dst   = 2'd2;
                reg_write = 1'b1;
                t_new_e   = 2'd2;
            end
            is_j: begin
                npc_op = NPC_J;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        if (int'(t_new_e) > TNEW_SUB) begin
            t_new = 2'(int'(t_new_e) - TNEW_SUB);
        end else begin
            t_new = 2'd0;
        end
    end

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_LUI: alu_res = {src_b[15:0], 16'h0000};
            ALU_SLL: alu_res = src_b << shamt;
`ifdef ALU_SLT_EN
            ALU_SLT: alu_res = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
`endif
            default: alu_res = 32'd0;
        endcase
    end

    assign zero = (src_a == src_b);

    logic [31:0] mem_q [DM_WORDS];
    logic [11:0] dm_idx;
    logic        dm_in_range;
    logic        wr_en_d;
    logic [31:0] wr_data_d;
    logic        unused_bits;

    assign dm_idx      = dm_addr[13:2];
    assign dm_in_range = (int'({20'd0, dm_idx}) < DM_WORDS);
    assign unused_bits = ^{instr[25:6], dm_addr[31:14], dm_addr[1:0]};

    always_comb begin
        wr_en_d   = dm_we && dm_in_range;
        wr_data_d = dm_wdata;
        dm_rdata  = 32'd0;
        if (dm_in_range) begin
            dm_rdata = mem_q[dm_idx];
        end
    end

    // Reset wipes the whole array at once and blocks writes while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en_d) begin
            mem_q[dm_idx] <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_ctrl_alu_dm_core.sv
// Scoreboard bench for ctrl_alu_dm_core: decode at all four stages, ALU, data memory.
// Honours ALU_SLT_EN for the slt expectations.
module tb_ctrl_alu_dm_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic        ext_o       [4];
    logic [2:0]  npc_o       [4];
    logic [3:0]  aop_o       [4];
    logic        alu_src_o   [4];
    logic        reg_write_o [4];
    logic        mem_write_o [4];
    logic [1:0]  reg_from_o  [4];
    logic [1:0]  reg_dst_o   [4];
    logic        t_use_rs_o  [4];
    logic [1:0]  t_use_rt_o  [4];
    logic [1:0]  t_new_o     [4];
    logic [31:0] alu_res_o   [4];
    logic        zero_o      [4];
    logic [31:0] dm_rdata_o  [4];

    always #5 clk = ~clk;

    for (genvar s = 0; s < 4; s++) begin : g_dut
        ctrl_alu_dm_core #(.STAGE(s)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .instr     (instr),
            .ext       (ext_o[s]),
            .npc_op    (npc_o[s]),
            .alu_op_o  (aop_o[s]),
            .alu_src   (alu_src_o[s]),
            .reg_write (reg_write_o[s]),
            .mem_write (mem_write_o[s]),
            .reg_from  (reg_from_o[s]),
            .reg_dst   (reg_dst_o[s]),
            .t_use_rs  (t_use_rs_o[s]),
            .t_use_rt  (t_use_rt_o[s]),
            .t_new     (t_new_o[s]),
            .alu_op    (alu_op),
            .shamt     (shamt),
            .src_a     (src_a),
            .src_b     (src_b),
            .alu_res   (alu_res_o[s]),
            .zero      (zero_o[s]),
            .dm_we     (dm_we),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_rdata  (dm_rdata_o[s])
        );
    end

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    function automatic logic [19:0] pk(
        input logic e, input logic [2:0] n, input logic [3:0] a,
        input logic src, input logic rw, input logic mw,
        input logic [1:0] rf, input logic [1:0] rd,
        input logic rs, input logic [1:0] rt, input logic [1:0] tn);
        return {e, n, a, src, rw, mw, rf, rd, rs, rt, tn};
    endfunction

    function automatic logic [19:0] obs_dec(input int s);
        return {ext_o[s], npc_o[s], aop_o[s], alu_src_o[s],
                reg_write_o[s], mem_write_o[s], reg_from_o[s],
                reg_dst_o[s], t_use_rs_o[s], t_use_rt_o[s], t_new_o[s]};
    endfunction

    function automatic logic [1:0] stage_tnew(input logic [1:0] e, input int s);
        case (s)
            0, 1:    return e;
            2:       return (e == 2'd0) ? 2'd0 : e - 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    task automatic alu_chk(input string t, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [31:0] e);
        alu_op = op;
        src_a  = a;
        src_b  = b;
        shamt  = sh;
        push(t, e);
        #1;
        pop_check(alu_res_o[0]);
    endtask

    task automatic zero_chk(input string t, input logic [31:0] a,
                            input logic [31:0] b, input logic e);
        src_a = a;
        src_b = b;
        push(t, {31'd0, e});
        #1;
        pop_check({31'd0, zero_o[0]});
    endtask

    task automatic dm_rd(input string t, input logic [31:0] a, input logic [31:0] e);
        dm_addr = a;
        push(t, e);
        #1;
        pop_check(dm_rdata_o[0]);
    endtask

    task automatic dm_wr(input logic [31:0] a, input logic [31:0] d);
        dm_we    = 1'b1;
        dm_addr  = a;
        dm_wdata = d;
        @(posedge clk);
        #1;
        dm_we = 1'b0;
    endtask

    string       d_name [15];
    logic [31:0] d_instr [15];
    logic [19:0] d_exp [15];

    initial begin
        reset    = 1'b1;
        instr    = 32'd0;
        alu_op   = 4'd0;
        shamt    = 5'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        dm_we    = 1'b0;
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;

        d_name[0]  = "add";  d_instr[0]  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        d_exp[0]   = pk(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 2'd1, 2'd1);
        d_name[1]  = "sub";  d_instr[1]  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22};
        d_exp[1]   = pk(1'b0, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 2'd1, 2'd1);
        d_name[2]  = "sll";  d_instr[2]  = {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00};
        d_exp[2]   = pk(1'b0, 3'd0, 4'd5, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 2'd1, 2'd1);
        d_name[3]  = "nop";  d_instr[3]  = 32'h0000_0000;
        d_exp[3]   = pk(1'b0, 3'd0, 4'd5, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 2'd1, 2'd1);
        d_name[4]  = "jr";   d_instr[4]  = {6'h00, 5'd31, 15'd0, 6'h08};
        d_exp[4]   = pk(1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 2'd0);
        d_name[5]  = "ori";  d_instr[5]  = {6'h0d, 5'd1, 5'd2, 16'h00ff};
        d_exp[5]   = pk(1'b0, 3'd0, 4'd2, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd1);
        d_name[6]  = "lui";  d_instr[6]  = {6'h0f, 5'd0, 5'd2, 16'h1234};
        d_exp[6]   = pk(1'b0, 3'd0, 4'd4, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd1);
        d_name[7]  = "lw";   d_instr[7]  = {6'h23, 5'd1, 5'd2, 16'hfffc};
        d_exp[7]   = pk(1'b1, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'd3, 2'd2);
        d_name[8]  = "sw";   d_instr[8]  = {6'h2b, 5'd1, 5'd2, 16'h0010};
        d_exp[8]   = pk(1'b1, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 2'd2, 2'd0);
        d_name[9]  = "beq";  d_instr[9]  = {6'h04, 5'd1, 5'd2, 16'h0003};
        d_exp[9]   = pk(1'b1, 3'd1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
        d_name[10] = "jal";  d_instr[10] = {6'h03, 26'h0000100};
        d_exp[10]  = pk(1'b0, 3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 1'b1, 2'd3, 2'd2);
        d_name[11] = "j";    d_instr[11] = {6'h02, 26'h0000100};
        d_exp[11]  = pk(1'b0, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0);
        d_name[12] = "unk3f"; d_instr[12] = {6'h3f, 26'h3ffffff};
        d_exp[12]  = pk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0);
        d_name[13] = "slt";  d_instr[13] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2a};
`ifdef ALU_SLT_EN
        d_exp[13]  = pk(1'b0, 3'd0, 4'd6, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 2'd1, 2'd1);
`else
        d_exp[13]  = pk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0);
`endif
        d_name[14] = "unk_r21"; d_instr[14] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        d_exp[14]  = pk(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0);

        #12;
        reset = 1'b0;
        dm_rd("reset_rd0", 32'h0, 32'h0);
        dm_rd("reset_rd10", 32'h10, 32'h0);

        for (int i = 0; i < 15; i++) begin
            instr = d_instr[i];
            for (int s = 0; s < 4; s++) begin
                push($sformatf("dec_%s_st%0d", d_name[i], s),
                     {12'd0, d_exp[i][19:2], stage_tnew(d_exp[i][1:0], s)});
            end
            #1;
            for (int s = 0; s < 4; s++) begin
                pop_check({12'd0, obs_dec(s)});
            end
        end

        alu_chk("alu_add_wrap", 4'd0, 32'h7fff_ffff, 32'h1, 5'd0, 32'h8000_0000);
        alu_chk("alu_add_ovf", 4'd0, 32'hffff_ffff, 32'h2, 5'd0, 32'h1);
        alu_chk("alu_sub", 4'd1, 32'h0, 32'h1, 5'd0, 32'hffff_ffff);
        alu_chk("alu_or", 4'd2, 32'hf0f0_0000, 32'h0000_0f0f, 5'd0, 32'hf0f0_0f0f);
        alu_chk("alu_and", 4'd3, 32'hff00_ff00, 32'h0ff0_0ff0, 5'd0, 32'h0f00_0f00);
        alu_chk("alu_lui", 4'd4, 32'hdead_beef, 32'hffff_1234, 5'd0, 32'h1234_0000);
        alu_chk("alu_sll31", 4'd5, 32'h0, 32'h1, 5'd31, 32'h8000_0000);
        alu_chk("alu_sll4", 4'd5, 32'h0, 32'h8000_00f1, 5'd4, 32'h0000_0f10);
`ifdef ALU_SLT_EN
        alu_chk("alu_slt_neg", 4'd6, 32'hffff_ffff, 32'h1, 5'd0, 32'h1);
        alu_chk("alu_slt_pos", 4'd6, 32'h1, 32'hffff_ffff, 5'd0, 32'h0);
`else
        alu_chk("alu_slt_off", 4'd6, 32'hffff_ffff, 32'h1, 5'd0, 32'h0);
`endif
        alu_chk("alu_op7", 4'd7, 32'h5, 32'h3, 5'd0, 32'h0);
        alu_chk("alu_op15", 4'd15, 32'hffff_ffff, 32'hffff_ffff, 5'd3, 32'h0);
        zero_chk("zero_eq", 32'h1234_5678, 32'h1234_5678, 1'b1);
        zero_chk("zero_ne", 32'h1234_5678, 32'h1234_5679, 1'b0);
        zero_chk("zero_msb", 32'h0, 32'h8000_0000, 1'b0);

        dm_wr(32'h10, 32'hdead_beef);
        dm_rd("dm_rd10", 32'h10, 32'hdead_beef);
        dm_rd("dm_rd13", 32'h13, 32'hdead_beef);
        dm_rd("dm_rd14", 32'h14, 32'h0);
        dm_rd("dm_rd0c", 32'h0c, 32'h0);

        dm_wr(32'h20, 32'd5);
        dm_we    = 1'b1;
        dm_addr  = 32'h20;
        dm_wdata = 32'd9;
        push("rdw_before", 32'd5);
        #1;
        pop_check(dm_rdata_o[0]);
        @(posedge clk);
        #1;
        dm_we = 1'b0;
        dm_rd("rdw_after", 32'h20, 32'd9);

        dm_wr(32'h3000, 32'h1234_5678);
        dm_rd("oor_rd", 32'h3000, 32'h0);
        dm_rd("oor_alias0", 32'h0, 32'h0);
        dm_wr(32'h2ffc, 32'hcafe_f00d);
        dm_rd("last_word", 32'h2ffc, 32'hcafe_f00d);

        dm_wr(32'h40, 32'h1111_1111);
        dm_wr(32'h44, 32'h2222_2222);
        dm_wr(32'h48, 32'h3333_3333);
        dm_wr(32'h4c, 32'h4444_4444);
        dm_rd("fill_48", 32'h48, 32'h3333_3333);
        reset = 1'b1;
        dm_rd("rst_40", 32'h40, 32'h0);
        dm_rd("rst_44", 32'h44, 32'h0);
        dm_rd("rst_48", 32'h48, 32'h0);
        dm_rd("rst_4c", 32'h4c, 32'h0);
        dm_rd("rst_10", 32'h10, 32'h0);
        dm_wr(32'h40, 32'h5555_5555);
        reset = 1'b0;
        dm_rd("rst_wr_lost", 32'h40, 32'h0);
        dm_wr(32'h44, 32'h6666_6666);
        dm_rd("post_rst_wr", 32'h44, 32'h6666_6666);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
